// File: rtl/sha_pad_gen.sv
// SHA message padder: writes 0x80, zero fill and the big-endian bit length up to a block boundary.
// Optional feature macro PAD_BASE_ADDR_EN adds a base_addr port that offsets every write address.
module sha_pad_gen #(
    parameter int ADDR_WIDTH  = 10,
    parameter int LEN_WIDTH   = 16,
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_BYTES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  msg_len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   num_blocks
`ifdef PAD_BASE_ADDR_EN
    ,
    input  logic [ADDR_WIDTH-1:0] base_addr
`endif
);

    localparam int TW = ((LEN_WIDTH > ADDR_WIDTH) ? LEN_WIDTH : ADDR_WIDTH) + 2;
    localparam int BW = $clog2(BLOCK_BYTES);
    localparam int KW = $clog2(LEN_BYTES) + 1;
    localparam int LW = LEN_BYTES * 8;
    localparam logic [TW-1:0] LEN_B    = TW'(LEN_BYTES);
    localparam logic [TW-1:0] BLK_B    = TW'(BLOCK_BYTES);
    localparam logic [TW-1:0] BLK_MASK = TW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] MEM_SIZE = TW'(2 ** ADDR_WIDTH);
    localparam logic [KW-1:0] K_LAST   = KW'(LEN_BYTES - 1);

    typedef enum logic [2:0] {IDLE, CALC, MARK, ZERO, LEN, DONE} state_t;

    logic [ADDR_WIDTH-1:0] base_in;
`ifdef PAD_BASE_ADDR_EN
    assign base_in = base_addr;
`else
    assign base_in = '0;
`endif

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [TW-1:0]         total_q, total_d;
    logic [TW-1:0]         off_q, off_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   num_blocks_q, num_blocks_d;

    logic [TW-1:0]         total_c, cap_c, field_c, off_inc;
    logic [LW-1:0]         lbits;
    logic [KW-1:0]         k_nxt;
    logic [7:0]            len_byte;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  accept;

    // Outputs are registered from the next-state view, so every output flop
    // already holds what the state being entered must present.
    always_comb begin
        total_c  = (TW'(len_q) + LEN_B + BLK_B) & ~BLK_MASK;
        cap_c    = MEM_SIZE - TW'(base_q);
        field_c  = total_q - LEN_B;
        off_inc  = off_q + 1'b1;
        addr_inc = base_q + ADDR_WIDTH'(off_inc);
        accept   = mem_we_q & mem_ready;
        lbits    = '0;
        lbits[LEN_WIDTH+2:0] = {len_q, 3'b000};
        k_nxt    = (state_q == LEN) ? k_q + 1'b1 : '0;
        len_byte = 8'((lbits << {k_nxt, 3'b000}) >> (LW - 8));

        state_d      = state_q;
        len_d        = len_q;
        base_d       = base_q;
        total_d      = total_q;
        off_d        = off_q;
        k_d          = k_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        num_blocks_d = num_blocks_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d        = msg_len;
                    base_d       = base_in;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    num_blocks_d = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                total_d      = total_c;
                num_blocks_d = (ADDR_WIDTH+1)'(total_c >> BW);
                if (total_c > cap_c) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    off_d       = TW'(len_q);
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_WIDTH'(len_q);
                    mem_wdata_d = 8'h80;
                    state_d     = MARK;
                end
            end
            MARK, ZERO: begin
                if (accept) begin
                    off_d      = off_inc;
                    mem_addr_d = addr_inc;
                    if (off_inc == field_c) begin
                        k_d         = '0;
                        mem_wdata_d = len_byte;
                        state_d     = LEN;
                    end else begin
                        mem_wdata_d = 8'h00;
                        state_d     = ZERO;
                    end
                end
            end
            LEN: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        mem_we_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        k_d         = k_nxt;
                        off_d       = off_inc;
                        mem_addr_d  = addr_inc;
                        mem_wdata_d = len_byte;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            base_q       <= '0;
            total_q      <= '0;
            off_q        <= '0;
            k_q          <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            num_blocks_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            base_q       <= base_d;
            total_q      <= total_d;
            off_q        <= off_d;
            k_q          <= k_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            num_blocks_q <= num_blocks_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign num_blocks = num_blocks_q;

endmodule

// File: tb/tb_sha_pad_gen.sv
// Scoreboard bench for sha_pad_gen (SHA-256 defaults, 1 KiB buffer, base address feature off).
module tb_sha_pad_gen;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   msg_len = '0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   num_blocks;

    always #5 clk = ~clk;

    sha_pad_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_len    (msg_len),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .num_blocks (num_blocks)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [AW:0] nb;
    } dn_t;

    wr_t         wq[$];
    dn_t         dq[$];
    wr_t         wexp;
    dn_t         dexp;
    logic [7:0]  img [1024];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          exp_first_cyc = 0;
    int          last_acc_cyc = -1;
    bit          first_pending = 0;
    bit          rand_ready = 0;
    bit          stalled = 0;
    logic [AW-1:0] st_addr;
    logic [7:0]    st_data;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: pops expected writes/completions and checks handshake timing.
    always @(negedge clk) begin
        if (!rst) begin
            stalled      = 0;
            last_acc_cyc = -1;
        end else begin
            if (stalled) begin
                checkOutput("stall_we", 32'(mem_we), 32'd1);
                checkOutput("stall_addr", 32'(mem_addr), 32'(st_addr));
                checkOutput("stall_data", 32'(mem_wdata), 32'(st_data));
            end
            if (first_pending && (mem_we || done)) begin
                checkOutput("first_latency", cyc, exp_first_cyc);
                first_pending = 0;
            end
            if (mem_we && mem_ready) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write addr=0x%0h data=0x%0h required=none", mem_addr, mem_wdata);
                end else begin
                    wexp = wq.pop_front();
                    checkOutput("wr_addr", 32'(mem_addr), 32'(wexp.addr));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(wexp.data));
                end
                img[mem_addr] = mem_wdata;
                wr_count++;
                last_acc_cyc = cyc;
            end
            stalled = mem_we && !mem_ready;
            st_addr = mem_addr;
            st_data = mem_wdata;
            if (done) begin
                done_count++;
                checkOutput("done_busy", 32'(busy), 32'd0);
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done err=%0d required=none", err);
                end else begin
                    dexp = dq.pop_front();
                    checkOutput("done_err", 32'(err), 32'(dexp.err));
                    checkOutput("done_blocks", 32'(num_blocks), 32'(dexp.nb));
                end
                if (last_acc_cyc >= 0) checkOutput("done_latency", cyc, last_acc_cyc + 1);
                last_acc_cyc = -1;
            end
        end
    end

    // Pushes the expected padding image for len and issues the start pulse.
    task automatic applyStimulus(input int len);
        int          total;
        logic [63:0] lbits;
        total = ((len + 1 + 8 + 63) / 64) * 64;
        lbits = 64'(len) * 64'd8;
        if (total > 1024) begin
            dq.push_back('{err: 1'b1, nb: 11'(total / 64)});
        end else begin
            wq.push_back('{addr: AW'(len), data: 8'h80});
            for (int a = len + 1; a < total - 8; a++) wq.push_back('{addr: AW'(a), data: 8'h00});
            for (int k = 0; k < 8; k++)
                wq.push_back('{addr: AW'(total - 8 + k), data: 8'(lbits >> (8 * (7 - k)))});
            dq.push_back('{err: 1'b0, nb: 11'(total / 64)});
        end
        foreach (img[i]) img[i] = 8'hEE;
        wr_count = 0;
        @(posedge clk);
        #1;
        msg_len       = 16'(len);
        start         = 1'b1;
        exp_first_cyc = cyc + 2;
        first_pending = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseStart(input int len);
        @(posedge clk);
        #1;
        msg_len = 16'(len);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int dc0;
        dc0 = done_count;
        for (int i = 0; i < 4000 && done_count == dc0; i++) @(posedge clk);
        checkOutput({name, "_completed"}, 32'(done_count != dc0), 32'd1);
        @(negedge clk);
        checkOutput({name, "_queue_empty"}, wq.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", 32'(mem_we), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_addr", 32'(mem_addr), 0);
        checkOutput("rst_blocks", 32'(num_blocks), 0);
        rst = 1'b1;

        applyStimulus(3);
        checkOutput("len3_busy", 32'(busy), 1);
        waitDone("len3");
        checkOutput("len3_mark", 32'(img[3]), 32'h80);
        checkOutput("len3_zero4", 32'(img[4]), 32'h00);
        checkOutput("len3_zero62", 32'(img[62]), 32'h00);
        checkOutput("len3_len63", 32'(img[63]), 32'h18);
        checkOutput("len3_writes", wr_count, 61);
        checkOutput("len3_blocks", 32'(num_blocks), 1);

        applyStimulus(55);
        waitDone("len55");
        checkOutput("len55_mark", 32'(img[55]), 32'h80);
        checkOutput("len55_b56", 32'(img[56]), 32'h00);
        checkOutput("len55_b62", 32'(img[62]), 32'h01);
        checkOutput("len55_b63", 32'(img[63]), 32'hB8);
        checkOutput("len55_writes", wr_count, 9);

        applyStimulus(56);
        waitDone("len56");
        checkOutput("len56_mark", 32'(img[56]), 32'h80);
        checkOutput("len56_zero119", 32'(img[119]), 32'h00);
        checkOutput("len56_b126", 32'(img[126]), 32'h01);
        checkOutput("len56_b127", 32'(img[127]), 32'hC0);
        checkOutput("len56_blocks", 32'(num_blocks), 2);

        applyStimulus(1016);
        waitDone("len1016");
        checkOutput("len1016_err", 32'(err), 1);
        checkOutput("len1016_writes", wr_count, 0);

        applyStimulus(1015);
        waitDone("len1015");
        checkOutput("len1015_err", 32'(err), 0);
        checkOutput("len1015_mark", 32'(img[1015]), 32'h80);
        checkOutput("len1015_b1022", 32'(img[1022]), 32'h1F);
        checkOutput("len1015_b1023", 32'(img[1023]), 32'hB8);
        checkOutput("len1015_blocks", 32'(num_blocks), 16);

        rand_ready = 1;
        applyStimulus(3);
        repeat (10) @(posedge clk);
        pulseStart(20);
        waitDone("stall3");
        rand_ready = 0;
        checkOutput("stall3_mark", 32'(img[3]), 32'h80);
        checkOutput("stall3_len63", 32'(img[63]), 32'h18);
        checkOutput("stall3_writes", wr_count, 61);

        applyStimulus(3);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
        dq.delete();
        first_pending = 0;
        @(posedge clk);
        #1;
        checkOutput("midrst_we", 32'(mem_we), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_addr", 32'(mem_addr), 0);
        checkOutput("midrst_data", 32'(mem_wdata), 0);
        rst = 1'b1;
        applyStimulus(10);
        waitDone("len10");
        checkOutput("len10_mark", 32'(img[10]), 32'h80);
        checkOutput("len10_b63", 32'(img[63]), 32'h50);
        checkOutput("len10_writes", wr_count, 54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
